// File: rtl/periph_init_pkg.sv
// Shared types for peripheral register-init sequencing:
// FSM states, table entry layout and the default end marker.
package periph_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_PAUSE,
        S_FINISH,
        S_FAILED
    } seq_state_e;

    localparam logic [7:0] END_MARK_DEF = 8'hFF;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] dly;
    } tbl_entry_t;

    function automatic tbl_entry_t mk_entry(
        input logic [7:0]  a,
        input logic [7:0]  d,
        input logic [15:0] dl
    );
        tbl_entry_t e;
        e.addr = a;
        e.data = d;
        e.dly  = dl;
        return e;
    endfunction

endpackage

// File: rtl/reg_init_rom.sv
// Per-device init tables as a combinational lookup.
// DEV 0: MPU wake/clock/filter setup; DEV 1: baro reset/config.
module reg_init_rom
    import periph_init_pkg::*;
#(
    parameter int          IDX_W = 3,
    parameter int          DEV   = 0,
    parameter logic [15:0] DLY   = 16'd512
) (
    input  logic [IDX_W-1:0] idx,
    output tbl_entry_t       entry
);

    always_comb begin
        entry = mk_entry(END_MARK_DEF, 8'h00, 16'h0000);
        if (DEV == 0) begin
            case (int'(idx))
                0:       entry = mk_entry(8'd107, 8'd128, DLY);
                1:       entry = mk_entry(8'd107, 8'd0,   DLY);
                2:       entry = mk_entry(8'd107, 8'd1,   DLY);
                3:       entry = mk_entry(8'd26,  8'd1,   DLY);
                4:       entry = mk_entry(8'd56,  8'd1,   DLY);
                default: ;
            endcase
        end else begin
            case (int'(idx))
                0:       entry = mk_entry(8'hE0, 8'hB6, DLY);
                1:       entry = mk_entry(8'hF5, 8'h10, DLY);
                2:       entry = mk_entry(8'hF4, 8'h57, DLY);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_init_seq.sv
// Table-driven register-init sequencer: one bus write per table
// entry with retry, wait timeout, end marker and post-write pause.
module reg_init_seq
    import periph_init_pkg::*;
#(
    parameter int N_ENTRIES  = 8,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DLY_W      = 16,
    parameter int TIMEOUT    = 4095,
    parameter int MAX_RETRY  = 3,
    parameter logic [ADDR_W-1:0] END_MARK = ADDR_W'(END_MARK_DEF),
    parameter bit AUTO_START = 1'b1,
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [IDX_W-1:0]  TBL_IDX,
    input  logic [ADDR_W-1:0] TBL_ADDR,
    input  logic [DATA_W-1:0] TBL_DATA,
    input  logic [DLY_W-1:0]  TBL_DLY,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic [DATA_W-1:0] BUS_WDATA,
    output logic              BUS_REQ,
    input  logic              BUS_DONE,
    input  logic              BUS_ERR,
    output logic              RUNNING,
    output logic              DONE,
    output logic              FAIL,
    output logic [IDX_W-1:0]  FAIL_IDX
);

    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic              auto_q, auto_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dly_q      <= '0;
            tmo_q      <= '0;
            rty_q      <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
            auto_q     <= AUTO_START;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            rty_q      <= rty_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
            auto_q     <= auto_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q;
        rty_d      = rty_q;
        done_d     = done_q;
        fail_d     = fail_q;
        fail_idx_d = fail_idx_q;
        auto_d     = auto_q;

        unique case (state_q)
            S_IDLE: begin
                if (START || auto_q) begin
                    auto_d  = 1'b0;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rty_d = '0;
                if (TBL_ADDR == END_MARK) begin
                    state_d = S_FINISH;
                end else begin
                    addr_d  = TBL_ADDR;
                    wdata_d = TBL_DATA;
                    dly_d   = TBL_DLY;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An error outranks a same-cycle completion.
                if (BUS_ERR || tmo_q == TMO_MAX) begin
                    if (rty_q < RTY_MAX) begin
                        rty_d   = rty_q + RTY_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FAILED;
                    end
                end else if (BUS_DONE) begin
                    rty_d   = '0;
                    state_d = S_PAUSE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_PAUSE: begin
                if (dly_q == '0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                addr_d  = '0;
                wdata_d = '0;
                state_d = S_IDLE;
            end
            S_FAILED: begin
                fail_d     = 1'b1;
                fail_idx_d = idx_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign TBL_IDX   = idx_q;
    assign BUS_ADDR  = addr_q;
    assign BUS_WDATA = wdata_q;
    assign BUS_REQ   = (state_q == S_ISSUE);
    assign RUNNING   = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT) || (state_q == S_PAUSE);
    assign DONE      = done_q;
    assign FAIL      = fail_q;
    assign FAIL_IDX  = fail_idx_q;

endmodule

// File: tb/tb_reg_init_seq.sv
// Directed bench for reg_init_seq: MPU table, retries, timeout,
// full table, mid-run reset, ignored START and DONE+ERR collision.
module tb_reg_init_seq;
    import periph_init_pkg::*;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_NONE = 2;
    localparam int K_BOTH = 3;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;
    } exp_req_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] tbl_idx;
    logic [7:0] tbl_addr;
    logic [7:0] tbl_data;
    logic [15:0] tbl_dly;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_req;
    logic       bus_done;
    logic       bus_err;
    logic       running;
    logic       done;
    logic       fail;
    logic [2:0] fail_idx;

    tbl_entry_t rom_ent;
    tbl_entry_t cur_ent;
    tbl_entry_t tb_tbl [8];
    bit         use_rom;

    int         plan_kind [64];
    int         plan_lat;
    int         req_cnt;
    logic [7:0] req_addr [64];
    logic [7:0] req_data [64];
    int         req_cyc [64];
    int         rsp_cyc [64];
    exp_req_t   vec [8];

    int cyc = 0;
    int n_cmp;
    int n_bad;

    reg_init_seq dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .TBL_IDX  (tbl_idx),
        .TBL_ADDR (tbl_addr),
        .TBL_DATA (tbl_data),
        .TBL_DLY  (tbl_dly),
        .BUS_ADDR (bus_addr),
        .BUS_WDATA(bus_wdata),
        .BUS_REQ  (bus_req),
        .BUS_DONE (bus_done),
        .BUS_ERR  (bus_err),
        .RUNNING  (running),
        .DONE     (done),
        .FAIL     (fail),
        .FAIL_IDX (fail_idx)
    );

    reg_init_rom #(.IDX_W(3), .DEV(0), .DLY(16'd512)) u_rom (
        .idx  (tbl_idx),
        .entry(rom_ent)
    );

    always_comb begin
        cur_ent = use_rom ? rom_ent : tb_tbl[tbl_idx];
    end
    assign tbl_addr = cur_ent.addr;
    assign tbl_data = cur_ent.data;
    assign tbl_dly  = cur_ent.dly;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    // Bus master model: answers each REQ per plan_kind after plan_lat WAIT cycles.
    initial begin : responder
        int cd;
        int k;
        cd = -1;
        k = 0;
        bus_done = 1'b0;
        bus_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_done = 1'b0;
            bus_err = 1'b0;
            if (rst) begin
                cd = -1;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus_done = (plan_kind[k] == K_DONE) || (plan_kind[k] == K_BOTH);
                        bus_err  = (plan_kind[k] == K_ERR) || (plan_kind[k] == K_BOTH);
                        rsp_cyc[k] = cyc;
                        cd = -1;
                    end
                end
                if (bus_req && req_cnt < 64) begin
                    k = req_cnt;
                    req_addr[k] = bus_addr;
                    req_data[k] = bus_wdata;
                    req_cyc[k] = cyc;
                    req_cnt++;
                    cd = (plan_kind[k] == K_NONE) ? -1 : plan_lat;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        n_cmp++;
        if (act < lim) begin
            n_bad++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
        end
    endtask

    task automatic set_vec(input int k, input logic [7:0] a, input logic [7:0] d, input int g);
        vec[k].addr = a;
        vec[k].data = d;
        vec[k].gap  = g;
    endtask

    task automatic check_reqs(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_req%0d_addr", tag, k), req_addr[k], vec[k].addr);
            chk($sformatf("%s_req%0d_data", tag, k), req_data[k], vec[k].data);
            if (vec[k].gap >= 0)
                chk($sformatf("%s_req%0d_gap", tag, k), req_cyc[k] - req_cyc[k-1], vec[k].gap);
        end
    endtask

    task automatic plan_all(input int kind, input int lat);
        for (int i = 0; i < 64; i++) plan_kind[i] = kind;
        plan_lat = lat;
    endtask

    task automatic mpu_tbl(input logic [15:0] dl);
        tb_tbl[0] = mk_entry(8'd107, 8'd128, dl);
        tb_tbl[1] = mk_entry(8'd107, 8'd0, dl);
        tb_tbl[2] = mk_entry(8'd107, 8'd1, dl);
        tb_tbl[3] = mk_entry(8'd26, 8'd1, dl);
        tb_tbl[4] = mk_entry(8'd56, 8'd1, dl);
        for (int i = 5; i < 8; i++) tb_tbl[i] = mk_entry(8'hFF, 8'h00, 16'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || fail) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("end_reached", 32'(done || fail), 1);
    endtask

    task automatic wait_reqs(input int cnt, input int budget);
        int n;
        n = 0;
        while (req_cnt < cnt && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("req_seen", 32'(req_cnt >= cnt), 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        use_rom = 1'b1;
        req_cnt = 0;
        mpu_tbl(16'd0);
        plan_all(K_DONE, 10);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_running", running, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_idx", tbl_idx, 0);
        chk("rst_fidx", fail_idx, 0);

        // Test 1: ROM MPU table, auto start, done after 10 cycles, dly 512
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("auto_running", running, 1);
        chk("auto_idx", tbl_idx, 0);
        wait_end(30000);
        set_vec(0, 8'd107, 8'd128, -1);
        set_vec(1, 8'd107, 8'd0, -1);
        set_vec(2, 8'd107, 8'd1, -1);
        set_vec(3, 8'd26, 8'd1, -1);
        set_vec(4, 8'd56, 8'd1, -1);
        chk("t1_nreq", req_cnt, 5);
        check_reqs("t1", 5);
        for (int k = 1; k < 5; k++)
            chk_ge($sformatf("t1_pause%0d", k), req_cyc[k] - rsp_cyc[k-1], 512);
        chk("t1_done", done, 1);
        chk("t1_fail", fail, 0);
        chk("t1_running", running, 0);
        chk("t1_addr_clr", bus_addr, 0);

        // Test 2: retries on entry 2, DONE+ERR collision on entry 3
        use_rom = 1'b0;
        mpu_tbl(16'd2);
        plan_all(K_DONE, 3);
        plan_kind[2] = K_ERR;
        plan_kind[3] = K_ERR;
        plan_kind[5] = K_BOTH;
        req_cnt = 0;
        pulse_start();
        chk("t2_done_clr", done, 0);
        wait_end(2000);
        set_vec(0, 8'd107, 8'd128, -1);
        set_vec(1, 8'd107, 8'd0, 8);
        set_vec(2, 8'd107, 8'd1, 8);
        set_vec(3, 8'd107, 8'd1, 4);
        set_vec(4, 8'd107, 8'd1, 4);
        set_vec(5, 8'd26, 8'd1, 8);
        set_vec(6, 8'd26, 8'd1, 4);
        set_vec(7, 8'd56, 8'd1, 8);
        chk("t2_nreq", req_cnt, 8);
        check_reqs("t2", 8);
        chk("t2_done", done, 1);
        chk("t2_fail", fail, 0);

        // Test 3: entry 1 never answered -> timeouts, retries exhausted
        plan_all(K_NONE, 1);
        plan_kind[0] = K_DONE;
        req_cnt = 0;
        pulse_start();
        wait_end(20000);
        set_vec(0, 8'd107, 8'd128, -1);
        set_vec(1, 8'd107, 8'd0, 6);
        set_vec(2, 8'd107, 8'd0, 4097);
        set_vec(3, 8'd107, 8'd0, 4097);
        set_vec(4, 8'd107, 8'd0, 4097);
        chk("t3_nreq", req_cnt, 5);
        check_reqs("t3", 5);
        chk("t3_fail", fail, 1);
        chk("t3_fidx", fail_idx, 1);
        chk("t3_done", done, 0);
        chk("t3_running", running, 0);

        // Test 4: full table, no end marker, dly 0; START mid-run ignored
        for (int i = 0; i < 8; i++)
            tb_tbl[i] = mk_entry(8'h10 + 8'(i), 8'hA0 + 8'(i), 16'd0);
        plan_all(K_DONE, 1);
        req_cnt = 0;
        pulse_start();
        chk("t4_fail_clr", fail, 0);
        chk("t4_running", running, 1);
        wait_reqs(3, 100);
        pulse_start();
        wait_end(500);
        for (int k = 0; k < 8; k++)
            set_vec(k, 8'h10 + 8'(k), 8'hA0 + 8'(k), (k == 0) ? -1 : 4);
        chk("t4_nreq", req_cnt, 8);
        check_reqs("t4", 8);
        chk("t4_idx_last", tbl_idx, 7);
        chk("t4_done", done, 1);

        // Test 5: reset in WAIT of entry 3, then auto restart from 0
        plan_all(K_DONE, 5);
        req_cnt = 0;
        pulse_start();
        wait_reqs(4, 200);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_running", running, 0);
        chk("t5_rst_req", bus_req, 0);
        chk("t5_rst_addr", bus_addr, 0);
        chk("t5_rst_wdata", bus_wdata, 0);
        chk("t5_rst_idx", tbl_idx, 0);
        chk("t5_rst_done", done, 0);
        repeat (4) @(posedge clk);
        #1;
        req_cnt = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_restart_running", running, 1);
        chk("t5_restart_idx", tbl_idx, 0);
        wait_end(500);
        chk("t5_nreq", req_cnt, 8);
        chk("t5_first_addr", req_addr[0], 8'h10);
        chk("t5_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
